// File: rtl/peripheral_responder.sv
// Command responder between a core port and two host-side FIFOs (RX from host, TX to host).
// One command is serviced at a time. DATA_WIDTH must be at least 16 so the STATUS word fits.
module peripheral_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    input  logic [DATA_WIDTH-1:0] host_in_data,
    input  logic                  host_in_valid,
    output logic                  host_in_ready,
    output logic [DATA_WIDTH-1:0] host_out_data,
    output logic                  host_out_valid,
    input  logic                  host_out_ready,
    output logic [7:0]            drop_count,
    output logic [1:0]            state_dbg
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, WAIT = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [1:0]            resp_code_q, resp_code_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [7:0]            drop_q, drop_d;

    logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [PTR_W-1:0]      tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [CNT_W-1:0]      rx_count_q, rx_count_d, tx_count_q, tx_count_d;

    logic                  rx_push, rx_pop, tx_push, tx_pop, cmd_live;
    logic [DATA_WIDTH-1:0] status_word;

    // Host ports use valid/ready: a word moves on a rising edge only when both are 1
    // in the cycle before it; valid is held with stable data until that edge.
    assign host_in_ready  = (rx_count_q < DEPTH_C);
    assign host_out_valid = (tx_count_q != '0);
    assign host_out_data  = tx_mem_q[tx_rptr_q];
    assign rx_push        = host_in_valid && host_in_ready;
    assign tx_pop         = host_out_valid && host_out_ready;
    assign cmd_live       = to_peripheral_valid && (to_peripheral != 2'b00);

    assign from_peripheral_valid = (state_q == RESP);
    assign from_peripheral       = from_peripheral_valid ? resp_code_q : 2'b00;
    assign from_peripheral_data  = from_peripheral_valid ? resp_data_q : '0;
    assign drop_count            = drop_q;
    assign state_dbg             = state_q;

    always_comb begin
        status_word       = '0;
        status_word[15:8] = 8'(tx_count_q);
        status_word[7:0]  = 8'(rx_count_q);
    end

    always_comb begin
        state_d     = state_q;
        resp_code_d = resp_code_q;
        resp_data_d = resp_data_q;
        drop_d      = drop_q;
        rx_pop      = 1'b0;
        tx_push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_live) begin
                    case (to_peripheral)
                        2'b01: begin
                            state_d     = RESP;
                            resp_data_d = '0;
                            if (tx_count_q != DEPTH_C) begin
                                tx_push                  = 1'b1;
                                resp_code_d              = 2'b01;
                                resp_data_d[CNT_W-1:0]   = tx_count_q + CNT_W'(1);
                            end else begin
                                resp_code_d = 2'b00;
                            end
                        end
                        2'b10: begin
                            if (rx_count_q != '0) begin
                                rx_pop      = 1'b1;
                                state_d     = RESP;
                                resp_code_d = 2'b10;
                                resp_data_d = rx_mem_q[rx_rptr_q];
                            end else begin
                                state_d = WAIT;
                            end
                        end
                        default: begin
                            state_d     = RESP;
                            resp_code_d = 2'b11;
                            resp_data_d = status_word;
                        end
                    endcase
                end
            end
            RESP: begin
                state_d = IDLE;
                if (cmd_live && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
            WAIT: begin
                if (cmd_live && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                // A host push lands first; the pop happens on the following edge.
                if (rx_count_q != '0) begin
                    rx_pop      = 1'b1;
                    state_d     = RESP;
                    resp_code_d = 2'b10;
                    resp_data_d = rx_mem_q[rx_rptr_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_mem_d  = rx_mem_q;
        tx_mem_d  = tx_mem_q;
        rx_wptr_d = rx_push ? rx_wptr_q + PTR_W'(1) : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + PTR_W'(1) : rx_rptr_q;
        tx_wptr_d = tx_push ? tx_wptr_q + PTR_W'(1) : tx_wptr_q;
        tx_rptr_d = tx_pop  ? tx_rptr_q + PTR_W'(1) : tx_rptr_q;
        if (rx_push) rx_mem_d[rx_wptr_q] = host_in_data;
        if (tx_push) tx_mem_d[tx_wptr_q] = to_peripheral_data;
        rx_count_d = rx_count_q;
        if (rx_push && !rx_pop) rx_count_d = rx_count_q + CNT_W'(1);
        else if (!rx_push && rx_pop) rx_count_d = rx_count_q - CNT_W'(1);
        tx_count_d = tx_count_q;
        if (tx_push && !tx_pop) tx_count_d = tx_count_q + CNT_W'(1);
        else if (!tx_push && tx_pop) tx_count_d = tx_count_q - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            resp_code_q <= 2'b00;
            resp_data_q <= '0;
            drop_q      <= 8'd0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_count_q  <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            resp_code_q <= resp_code_d;
            resp_data_q <= resp_data_d;
            drop_q      <= drop_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_count_q  <= rx_count_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_count_q  <= tx_count_d;
        end
    end

    // Storage needs no reset: pointers and counts decide what is readable.
    always_ff @(posedge clock) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end
endmodule

// File: tb/tb_peripheral_responder.sv
// Scoreboard bench for peripheral_responder: expected core responses and host TX words are queued
// when stimulus is driven and compared when the DUT presents them.
module tb_peripheral_responder;
    localparam int W = 32;
    localparam logic [1:0] C_NONE = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_STATUS = 2'b11;
    localparam logic [1:0] S_IDLE = 2'd0, S_RESP = 2'd1, S_WAIT = 2'd2;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   to_peripheral;
    logic [W-1:0] to_peripheral_data;
    logic         to_peripheral_valid;
    logic [1:0]   from_peripheral;
    logic [W-1:0] from_peripheral_data;
    logic         from_peripheral_valid;
    logic [W-1:0] host_in_data;
    logic         host_in_valid;
    logic         host_in_ready;
    logic [W-1:0] host_out_data;
    logic         host_out_valid;
    logic         host_out_ready;
    logic [7:0]   drop_count;
    logic [1:0]   state_dbg;

    logic [W+1:0] exp_q[$];
    logic [W-1:0] exp_tx_q[$];
    int           n_total = 0;
    int           n_bad = 0;
    bit           mon_en = 1'b0;

    peripheral_responder #(.DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .to_peripheral(to_peripheral), .to_peripheral_data(to_peripheral_data),
        .to_peripheral_valid(to_peripheral_valid),
        .from_peripheral(from_peripheral), .from_peripheral_data(from_peripheral_data),
        .from_peripheral_valid(from_peripheral_valid),
        .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
        .host_out_data(host_out_data), .host_out_valid(host_out_valid),
        .host_out_ready(host_out_ready),
        .drop_count(drop_count), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard monitors
    always @(negedge clock) begin
        if (mon_en) begin
            if (from_peripheral_valid) begin
                if (exp_q.size() == 0) check_eq("unexpected_resp", 64'(from_peripheral_valid), 64'd0);
                else check_eq("resp", 64'({from_peripheral, from_peripheral_data}), 64'(exp_q.pop_front()));
            end else begin
                check_eq("idle_zero", 64'({from_peripheral, from_peripheral_data}), 64'd0);
            end
            if (host_out_valid && host_out_ready) begin
                if (exp_tx_q.size() == 0) check_eq("unexpected_tx", 64'(host_out_valid), 64'd0);
                else check_eq("tx_word", 64'(host_out_data), 64'(exp_tx_q.pop_front()));
            end
        end
    end

    // driver tasks: every task starts and ends 1ns after a rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cmd(input logic [1:0] c, input logic [W-1:0] d);
        to_peripheral       = c;
        to_peripheral_data  = d;
        to_peripheral_valid = 1'b1;
        tick();
        to_peripheral_valid = 1'b0;
        to_peripheral       = C_NONE;
    endtask

    task automatic do_write(input logic [W-1:0] d, input int ack_n);
        if (ack_n == 0) exp_q.push_back({C_NONE, {W{1'b0}}});
        else begin
            exp_q.push_back({C_WRITE, W'(ack_n)});
            exp_tx_q.push_back(d);
        end
        cmd(C_WRITE, d);
        tick();
    endtask

    task automatic host_push(input logic [W-1:0] w);
        bit done = 1'b0;
        host_in_data  = w;
        host_in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            if (host_in_ready) done = 1'b1;
            tick();
        end
        host_in_valid = 1'b0;
        if (!done) check_eq("host_push_timeout", 64'(host_in_ready), 64'd1);
    endtask

    task automatic drain(input int n);
        host_out_ready = 1'b1;
        repeat (n) tick();
        host_out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w0, w1, rd;
        int m_tx;
        reset = 1'b0;
        to_peripheral = C_NONE; to_peripheral_data = '0; to_peripheral_valid = 1'b0;
        host_in_data = '0; host_in_valid = 1'b0; host_out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_valid", 64'(from_peripheral_valid), 64'd0);
        check_eq("rst_hov", 64'(host_out_valid), 64'd0);
        check_eq("rst_hir", 64'(host_in_ready), 64'd1);
        check_eq("rst_drop", 64'(drop_count), 64'd0);
        check_eq("rst_state", 64'(state_dbg), 64'(S_IDLE));
        mon_en = 1'b1;
        tick();

        // single WRITE, then check the TX head is presented
        do_write(32'hDEADBEEF, 1);
        @(negedge clock);
        check_eq("w1_hov", 64'(host_out_valid), 64'd1);
        check_eq("w1_hod", 64'(host_out_data), 64'hDEADBEEF);
        tick();
        drain(2);

        // fill TX to depth, fifth WRITE is NACKed
        for (int i = 1; i <= 4; i++) do_write(32'h1000_0000 + W'(i), i);
        do_write(32'hBAD0BAD0, 0);
        @(negedge clock);
        check_eq("full_hir_side", 64'(host_out_valid), 64'd1);
        tick();
        drain(6);
        @(negedge clock);
        check_eq("drained_hov", 64'(host_out_valid), 64'd0);
        tick();

        // ignored null command
        cmd(C_NONE, 32'h5555_5555);
        @(negedge clock);
        check_eq("null_state", 64'(state_dbg), 64'(S_IDLE));
        check_eq("null_drop", 64'(drop_count), 64'd0);
        tick();

        // STATUS with RX=2, TX=3, then READs in order
        w0 = $urandom; w1 = $urandom;
        host_push(w0);
        host_push(w1);
        for (int i = 1; i <= 3; i++) do_write($urandom, i);
        exp_q.push_back({C_STATUS, 32'h0000_0302});
        cmd(C_STATUS, '0); tick();
        exp_q.push_back({C_READ, w0});
        cmd(C_READ, '0); tick();
        exp_q.push_back({C_READ, w1});
        cmd(C_READ, '0); tick();
        drain(5);

        // READ on empty RX waits for the host
        cmd(C_READ, '0);
        @(negedge clock);
        check_eq("wait_state", 64'(state_dbg), 64'(S_WAIT));
        check_eq("wait_novalid", 64'(from_peripheral_valid), 64'd0);
        tick();
        tick();
        exp_q.push_back({C_READ, 32'h12345678});
        host_push(32'h12345678);
        @(negedge clock);
        check_eq("wait_hold", 64'(from_peripheral_valid), 64'd0);
        tick();
        @(negedge clock);
        check_eq("wait_resp", 64'(from_peripheral_valid), 64'd1);
        tick();
        @(negedge clock);
        check_eq("wait_back_idle", 64'(state_dbg), 64'(S_IDLE));
        tick();

        // drops while waiting, saturating at 255
        cmd(C_READ, '0);
        to_peripheral = C_STATUS; to_peripheral_valid = 1'b1;
        repeat (3) tick();
        to_peripheral_valid = 1'b0;
        @(negedge clock);
        check_eq("drop3", 64'(drop_count), 64'd3);
        tick();
        to_peripheral = C_WRITE; to_peripheral_valid = 1'b1;
        repeat (257) tick();
        to_peripheral_valid = 1'b0; to_peripheral = C_NONE;
        @(negedge clock);
        check_eq("drop_sat", 64'(drop_count), 64'd255);
        check_eq("drop_no_tx", 64'(host_out_valid), 64'd0);
        tick();
        rd = $urandom;
        exp_q.push_back({C_READ, rd});
        host_push(rd);
        tick(); tick();

        // reset during WAIT with TX partly full; inputs in the reset cycle are ignored
        do_write(32'hAAAA0001, 1);
        do_write(32'hAAAA0002, 2);
        cmd(C_READ, '0);
        reset = 1'b0;
        host_in_data = 32'h77; host_in_valid = 1'b1;
        to_peripheral = C_WRITE; to_peripheral_valid = 1'b1;
        tick();
        reset = 1'b1; host_in_valid = 1'b0; to_peripheral_valid = 1'b0; to_peripheral = C_NONE;
        exp_tx_q.delete();
        @(negedge clock);
        check_eq("mid_rst_valid", 64'(from_peripheral_valid), 64'd0);
        check_eq("mid_rst_hov", 64'(host_out_valid), 64'd0);
        check_eq("mid_rst_hir", 64'(host_in_ready), 64'd1);
        check_eq("mid_rst_drop", 64'(drop_count), 64'd0);
        check_eq("mid_rst_state", 64'(state_dbg), 64'(S_IDLE));
        tick();
        do_write(32'hCAFE0001, 1);
        cmd(C_READ, '0);
        @(negedge clock);
        check_eq("rst_ignored_rx", 64'(state_dbg), 64'(S_WAIT));
        tick();
        rd = $urandom;
        exp_q.push_back({C_READ, rd});
        host_push(rd);
        tick(); tick();
        drain(3);

        // random WRITE / STATUS / null mix against a TX count model
        m_tx = 0;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0: begin cmd(C_NONE, $urandom); tick(); end
                1: begin
                    if (m_tx < 4) begin m_tx++; do_write($urandom, m_tx); end
                    else do_write($urandom, 0);
                end
                default: begin
                    exp_q.push_back({C_STATUS, W'(m_tx) << 8});
                    cmd(C_STATUS, $urandom); tick();
                end
            endcase
        end
        drain(6);

        repeat (3) tick();
        check_eq("resp_q_empty", 64'(exp_q.size()), 64'd0);
        check_eq("tx_q_empty", 64'(exp_tx_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
